// File: rtl/strela_cfg_pkg.sv
// Shared types and constants for the PE configuration loader.
//   cfg_ld_state_t : loader FSM state encoding
//   CFG_BITS / EN_BITS / PE_IMG_BITS : per-PE image geometry
//   WORD_BITS / WORDS_PER_PE : input word geometry (32-bit words, 5 per PE)
package strela_cfg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CATCH, DONE} cfg_ld_state_t;

    localparam int unsigned CFG_BITS     = 144;
    localparam int unsigned EN_BITS      = 6;
    localparam int unsigned PE_IMG_BITS  = 150;
    localparam int unsigned WORD_BITS    = 32;
    localparam int unsigned WORDS_PER_PE = 5;
    localparam int unsigned WCNT_W       = 3;
    // Bits carried by the final word of a PE image; its upper bits are dropped.
    localparam int unsigned LAST_BITS    = PE_IMG_BITS - (WORDS_PER_PE - 1) * WORD_BITS;

endpackage

// File: rtl/cfg_word_assembler.sv
// Packs five 32-bit config words into one 150-bit PE image.
//   clk   : clock
//   rst   : synchronous active-high reset; clears word counter and image
//   wr    : word transfer strobe (valid && ready)
//   din   : config word
//   last  : high when the current transfer is the fifth word of an image
//   image : assembled image register (held until overwritten)
module cfg_word_assembler
    import strela_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WORD_BITS-1:0]   din,
    output logic                   last,
    output logic [PE_IMG_BITS-1:0] image
);

    logic [WCNT_W-1:0] word_cnt;

    assign last = wr && (word_cnt == WCNT_W'(WORDS_PER_PE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            image    <= '0;
        end else if (wr) begin
            word_cnt <= last ? '0 : word_cnt + WCNT_W'(1);
            unique case (word_cnt)
                3'd0: image[0*WORD_BITS +: WORD_BITS] <= din;
                3'd1: image[1*WORD_BITS +: WORD_BITS] <= din;
                3'd2: image[2*WORD_BITS +: WORD_BITS] <= din;
                3'd3: image[3*WORD_BITS +: WORD_BITS] <= din;
                // Only the low LAST_BITS of word 4 fit in the image.
                3'd4: image[4*WORD_BITS +: LAST_BITS] <= din[LAST_BITS-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pe_config_loader.sv
// Streams PE configurations from a 32-bit valid/ready source into the CGRA array.
// Five words form one PE image, which is broadcast on config_bits/config_enables while
// the target PE's catch_config strobe pulses for one cycle. PEs 0..count-1 load in order.
//   clk, rst          : clock (shared with PE clk_bs), synchronous active-high reset
//   start, num_pes    : load request (IDLE only) and PE count sampled with it
//   cfg_din/_v/_r     : config word stream
//   config_bits       : broadcast config image
//   config_enables    : broadcast enable image
//   catch_config      : one-hot capture strobe
//   busy, done        : run in progress / 1-cycle completion pulse
module pe_config_loader #(
    parameter int unsigned NUM_PES    = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CFG_BITS   = 144,
    parameter int unsigned EN_BITS    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(NUM_PES+1)-1:0] num_pes,
    input  logic [DATA_WIDTH-1:0]        cfg_din,
    input  logic                         cfg_din_v,
    output logic                         cfg_din_r,
    output logic [CFG_BITS-1:0]          config_bits,
    output logic [EN_BITS-1:0]           config_enables,
    output logic [NUM_PES-1:0]           catch_config,
    output logic                         busy,
    output logic                         done
);
    import strela_cfg_pkg::*;

    localparam int unsigned CNT_W = $clog2(NUM_PES + 1);

    cfg_ld_state_t              state;
    logic [CNT_W-1:0]           pe_idx;
    logic [CNT_W-1:0]           count;
    logic                       wr;
    logic                       last;
    logic [PE_IMG_BITS-1:0]     image;

    // cfg_din_r is only ever high in LOAD, so this is the transfer condition.
    assign wr = cfg_din_v && cfg_din_r;

    cfg_word_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .din   (cfg_din),
        .last  (last),
        .image (image)
    );

    assign config_bits    = image[CFG_BITS-1:0];
    assign config_enables = image[CFG_BITS +: EN_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pe_idx       <= '0;
            count        <= '0;
            cfg_din_r    <= 1'b0;
            catch_config <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            catch_config <= '0;
            done         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_pes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            count     <= (num_pes > CNT_W'(NUM_PES)) ? CNT_W'(NUM_PES) : num_pes;
                            pe_idx    <= '0;
                            state     <= LOAD;
                            busy      <= 1'b1;
                            cfg_din_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (last) begin
                        state        <= CATCH;
                        cfg_din_r    <= 1'b0;
                        catch_config <= NUM_PES'(1) << pe_idx;
                    end
                end
                CATCH: begin
                    if (pe_idx == count - CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pe_idx    <= pe_idx + CNT_W'(1);
                        state     <= LOAD;
                        cfg_din_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    pe_idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
module tb_pe_config_loader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   num_pes;
    logic [31:0]  cfg_din;
    logic         cfg_din_v;
    logic         cfg_din_r;
    logic [143:0] config_bits;
    logic [5:0]   config_enables;
    logic [15:0]  catch_config;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, sampled on the falling edge
    logic [15:0]  cat_log [$];
    logic [149:0] img_log [$];
    int           done_cnt = 0;
    int           busy_drop = 0;
    logic         run_active = 1'b0;

    pe_config_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_pes        (num_pes),
        .cfg_din        (cfg_din),
        .cfg_din_v      (cfg_din_v),
        .cfg_din_r      (cfg_din_r),
        .config_bits    (config_bits),
        .config_enables (config_enables),
        .catch_config   (catch_config),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (catch_config != 16'h0) begin
            cat_log.push_back(catch_config);
            img_log.push_back({config_enables, config_bits});
        end
        if (done) done_cnt++;
        if (run_active && !busy && !done) busy_drop++;
    end

    function automatic logic [149:0] build_img(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3,
                                                input logic [31:0] w4);
        return {w4[21:0], w3, w2, w1, w0};
    endfunction

    function automatic logic [31:0] wgen(input int p, input int k);
        return 32'hC3A5_0000 ^ (p << 12) ^ (k << 4) ^ (p * 7 + k + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        start   = 1'b1;
        num_pes = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int bub);
        int tmo;
        repeat (bub) begin
            cfg_din_v = 1'b0;
            tick();
        end
        cfg_din   = w;
        cfg_din_v = 1'b1;
        tmo = 0;
        while (cfg_din_r !== 1'b1 && tmo < 50) begin
            tick();
            tmo++;
        end
        n_checks++;
        if (tmo >= 50) begin
            $display("FAIL send_word_timeout: cfg_din_r=%b, required 1 within 50 cycles", cfg_din_r);
            n_fail++;
        end
        tick();
        cfg_din_v = 1'b0;
    endtask

    task automatic send_pe(input int p, input int maxb);
        for (int k = 0; k < 5; k++) send_word(wgen(p, k), $urandom_range(0, maxb));
    endtask

    task automatic wait_done(input int max_cyc);
        int c;
        c = 0;
        while (done !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            $display("FAIL wait_done_timeout: done=%b, required 1 within %0d cycles", done, max_cyc);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({catch_config, done, busy, cfg_din_r} !== 19'h0) begin
            $display("FAIL reset_ctrl: catch=%h done=%b busy=%b rdy=%b, required all 0",
                     catch_config, done, busy, cfg_din_r);
            n_fail++;
        end
        n_checks++;
        if ({config_enables, config_bits} !== 150'h0) begin
            $display("FAIL reset_image: en=%h bits=%h, required 0", config_enables, config_bits);
            n_fail++;
        end
    endtask

    task automatic test_single();
        logic [149:0] exp;
        exp = build_img(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        pulse_start(5'd1);
        n_checks++;
        if (busy !== 1'b1 || cfg_din_r !== 1'b1) begin
            $display("FAIL single_load_entry: busy=%b rdy=%b, required 1 1", busy, cfg_din_r);
            n_fail++;
        end
        for (int k = 1; k <= 5; k++) send_word(32'(k), 0);
        // Cycle 7 counting the start cycle as cycle 1: the CATCH cycle.
        n_checks++;
        if (catch_config !== 16'h0001 || cfg_din_r !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_catch: catch=%h rdy=%b busy=%b, required 0001 0 1",
                     catch_config, cfg_din_r, busy);
            n_fail++;
        end
        n_checks++;
        if (config_bits[31:0] !== 32'd1 || config_bits[143:128] !== 16'h0005 ||
            config_enables !== 6'h0 || {config_enables, config_bits} !== exp) begin
            $display("FAIL single_image: got %h, required %h", {config_enables, config_bits}, exp);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || catch_config !== 16'h0) begin
            $display("FAIL single_done: done=%b busy=%b catch=%h, required 1 0 0000",
                     done, busy, catch_config);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || {config_enables, config_bits} !== exp) begin
            $display("FAIL single_after_done: done=%b image=%h, required 0 %h",
                     done, {config_enables, config_bits}, exp);
            n_fail++;
        end
    endtask

    task automatic test_multi_bubbles();
        int d0;
        int nbad;
        logic [149:0] exp;
        cat_log.delete();
        img_log.delete();
        d0 = done_cnt;
        busy_drop = 0;
        pulse_start(5'd3);
        run_active = 1'b1;
        for (int p = 0; p < 3; p++) send_pe(p, 3);
        wait_done(50);
        run_active = 1'b0;
        tick();
        n_checks++;
        if (cat_log.size() != 3) begin
            $display("FAIL multi_catch_count: got %0d, required 3", cat_log.size());
            n_fail++;
        end
        nbad = 0;
        for (int p = 0; p < 3 && p < cat_log.size(); p++) begin
            exp = build_img(wgen(p, 0), wgen(p, 1), wgen(p, 2), wgen(p, 3), wgen(p, 4));
            n_checks++;
            if (cat_log[p] !== (16'h1 << p) || img_log[p] !== exp) begin
                $display("FAIL multi_pe%0d: catch=%h image=%h, required %h %h",
                         p, cat_log[p], img_log[p], 16'h1 << p, exp);
                n_fail++;
                nbad++;
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1 || busy_drop != 0) begin
            $display("FAIL multi_done_busy: done pulses=%0d busy drops=%0d, required 1 0",
                     done_cnt - d0, busy_drop);
            n_fail++;
        end
    endtask

    task automatic test_last_word();
        pulse_start(5'd1);
        for (int k = 0; k < 4; k++) send_word(32'hA000_0000 + 32'(k), 0);
        send_word(32'hFFC0_0015, 0);
        n_checks++;
        if (catch_config !== 16'h0001 || config_enables !== 6'h00 ||
            config_bits[143:128] !== 16'h0015) begin
            $display("FAIL last_word_a: catch=%h en=%h hi=%h, required 0001 00 0015",
                     catch_config, config_enables, config_bits[143:128]);
            n_fail++;
        end
        wait_done(5);
        tick();
        pulse_start(5'd1);
        for (int k = 0; k < 4; k++) send_word(32'hB000_0000 + 32'(k), 1);
        send_word(32'hFFD5_0000, 0);
        n_checks++;
        if (catch_config !== 16'h0001 || config_enables !== 6'h15 ||
            config_bits[143:128] !== 16'h0000 || config_bits[127:96] !== 32'hB000_0003) begin
            $display("FAIL last_word_b: catch=%h en=%h hi=%h w3=%h, required 0001 15 0000 b0000003",
                     catch_config, config_enables, config_bits[143:128], config_bits[127:96]);
            n_fail++;
        end
        wait_done(5);
        tick();
        tick();
        n_checks++;
        if (config_enables !== 6'h15 || config_bits[31:0] !== 32'hB000_0000) begin
            $display("FAIL last_word_hold: en=%h w0=%h, required 15 b0000000",
                     config_enables, config_bits[31:0]);
            n_fail++;
        end
    endtask

    task automatic test_count_bounds();
        int nbad;
        int d0;
        logic [149:0] exp;
        cat_log.delete();
        img_log.delete();
        d0 = done_cnt;
        pulse_start(5'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_din_r !== 1'b0) begin
            $display("FAIL zero_done: done=%b busy=%b rdy=%b, required 1 0 0", done, busy, cfg_din_r);
            n_fail++;
        end
        tick();
        tick();
        n_checks++;
        if (cat_log.size() != 0 || cfg_din_r !== 1'b0 || done_cnt - d0 != 1) begin
            $display("FAIL zero_quiet: catches=%0d rdy=%b done pulses=%0d, required 0 0 1",
                     cat_log.size(), cfg_din_r, done_cnt - d0);
            n_fail++;
        end
        pulse_start(5'd20);
        for (int p = 0; p < 16; p++) send_pe(p, 0);
        wait_done(10);
        tick();
        n_checks++;
        if (cat_log.size() != 16) begin
            $display("FAIL clamp_count: got %0d catches, required 16", cat_log.size());
            n_fail++;
        end
        nbad = 0;
        for (int p = 0; p < 16 && p < cat_log.size(); p++) begin
            exp = build_img(wgen(p, 0), wgen(p, 1), wgen(p, 2), wgen(p, 3), wgen(p, 4));
            if (cat_log[p] !== (16'h1 << p) || img_log[p] !== exp) nbad++;
        end
        n_checks++;
        if (nbad != 0) begin
            $display("FAIL clamp_order: got %0d bad catches, required 0", nbad);
            n_fail++;
        end
    endtask

    task automatic test_abort_restart();
        int n0;
        logic [149:0] exp;
        cat_log.delete();
        img_log.delete();
        pulse_start(5'd2);
        send_pe(0, 0);
        for (int k = 0; k < 3; k++) send_word(wgen(1, k), 0);
        // rst and start together: rst must win
        rst     = 1'b1;
        start   = 1'b1;
        num_pes = 5'd1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({catch_config, done, busy, cfg_din_r} !== 19'h0 ||
            {config_enables, config_bits} !== 150'h0) begin
            $display("FAIL abort_reset: catch=%h done=%b busy=%b rdy=%b image=%h, required all 0",
                     catch_config, done, busy, cfg_din_r, {config_enables, config_bits});
            n_fail++;
        end
        cfg_din   = wgen(1, 3);
        cfg_din_v = 1'b1;
        repeat (8) tick();
        cfg_din_v = 1'b0;
        n_checks++;
        if (cat_log.size() != 1 || busy !== 1'b0 || cfg_din_r !== 1'b0) begin
            $display("FAIL abort_quiet: catches=%0d busy=%b rdy=%b, required 1 0 0",
                     cat_log.size(), busy, cfg_din_r);
            n_fail++;
        end
        n0 = cat_log.size();
        pulse_start(5'd1);
        pulse_start(5'd3);
        for (int k = 0; k < 5; k++) begin
            send_word(wgen(9, k), 1);
            if (k == 2) pulse_start(5'd3);
        end
        wait_done(5);
        tick();
        repeat (8) tick();
        exp = build_img(wgen(9, 0), wgen(9, 1), wgen(9, 2), wgen(9, 3), wgen(9, 4));
        n_checks++;
        if (cat_log.size() - n0 != 1) begin
            $display("FAIL restart_count: got %0d catches, required 1", cat_log.size() - n0);
            n_fail++;
        end else begin
            n_checks++;
            if (cat_log[n0] !== 16'h0001 || img_log[n0] !== exp) begin
                $display("FAIL restart_image: catch=%h image=%h, required 0001 %h",
                         cat_log[n0], img_log[n0], exp);
                n_fail++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_pes   = '0;
        cfg_din   = '0;
        cfg_din_v = 1'b0;
        test_reset();
        test_single();
        test_multi_bubbles();
        test_last_word();
        test_count_bounds();
        test_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
